// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles every non-clock signal of the two-requester RAM arbiter.
//   slave  modport: arbiter side. It takes requests and RAM status, and drives
//                   stalls, read data, RAM controls and debug outputs.
//   master modport: environment side, which is the caches plus the RAM.
// Signals:
//   req_ren/req_wen    per-requester read/write request, index 0 = core 0
//   req_addr/req_store per-requester address / write data, requester i at [i*W +: W]
//   req_wait           per-requester stall, low only in that requester's completion cycle
//   req_load           read data for the requester whose req_wait is low
//   memREN/memWEN/memaddr/memstore  RAM-side request
//   ramload/ramstate   RAM read data and status (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
//   owner/busy         current grant index and busy flag
//   txn_cnt            completed transactions, requester i at [i*CW +: CW]
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic [1:0]        req_ren;
    logic [1:0]        req_wen;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_store;
    logic [1:0]        req_wait;
    logic [DW-1:0]     req_load;
    logic              memREN;
    logic              memWEN;
    logic [AW-1:0]     memaddr;
    logic [DW-1:0]     memstore;
    logic [DW-1:0]     ramload;
    logic [1:0]        ramstate;
    logic              owner;
    logic              busy;
    logic [2*CW-1:0]   txn_cnt;

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, memREN, memWEN, memaddr, memstore, owner, busy, txn_cnt
    );

    modport master (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, memREN, memWEN, memaddr, memstore, owner, busy, txn_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares a single RAM port between two cores.
// It grants one complete RAM transaction at a time and holds the grant until RAM
// reports ACCESS. After each completion it rotates priority. It also keeps a
// per-requester count of completed transactions.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  mem_arbiter_if.slave, which carries the request, RAM and debug signals
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic                owner_q;
    logic                prio;
    logic [1:0][CW-1:0]  cnt;

    logic [1:0] active;
    logic       own_ren;
    logic       own_wen;
    logic       own_active;
    logic       done;

    // The owner's live request decides everything while BUSY. A transaction
    // completes only if the owner still requests in the cycle RAM says ACCESS.
    always_comb begin
        active     = bus.req_ren | bus.req_wen;
        own_ren    = bus.req_ren[owner_q];
        own_wen    = bus.req_wen[owner_q];
        own_active = own_ren | own_wen;
        done       = (state == BUSY) && own_active && (bus.ramstate == RAM_ACCESS);
    end

    // Grant / completion FSM. Priority only rotates on a real completion.
    // An abort (the owner drops its request) leaves prio and the counters untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            prio    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active != 2'b00) begin
                        state   <= BUSY;
                        owner_q <= (active == 2'b11) ? prio : active[1];
                    end
                end
                BUSY: begin
                    if (!own_active) begin
                        state <= IDLE;
                    end else if (done) begin
                        cnt[owner_q] <= cnt[owner_q] + CW'(1);
                        prio         <= ~owner_q;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM-side outputs follow the owner's live inputs. A write takes precedence
    // over a read, and everything is zero in IDLE. The owner's stall is released
    // only in the completion cycle.
    always_comb begin
        bus.memREN   = 1'b0;
        bus.memWEN   = 1'b0;
        bus.memaddr  = '0;
        bus.memstore = '0;
        bus.req_wait = 2'b11;
        bus.req_load = '0;
        if (state == BUSY) begin
            bus.memWEN   = own_wen;
            bus.memREN   = own_ren & ~own_wen;
            bus.memaddr  = owner_q ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
            bus.memstore = owner_q ? bus.req_store[2*DW-1:DW] : bus.req_store[DW-1:0];
        end
        if (done) begin
            bus.req_wait[owner_q] = 1'b0;
            bus.req_load          = bus.ramload;
        end
    end

    assign bus.busy    = (state == BUSY);
    assign bus.owner   = (state == BUSY) & owner_q;
    assign bus.txn_cnt = cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// It starts with directed scenarios that carry hand-computed expectations, then
// runs a randomized phase. In the randomized phase each requester follows the
// hold-until-served protocol, with occasional aborts. A transaction-level model
// checks every output on every falling edge.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] RBUSY  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK;
    logic RST;

    mem_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int compared   = 0;
    int mismatched = 0;

    // Reference state: who holds the grant (-1 = nobody), the tie-break favourite
    // and the completed-transaction tallies.
    int mCur  = -1;
    int mPrio = 0;
    int mCnt [2] = '{0, 0};

    // Literal expectations for the current cycle, written by the directed
    // scenarios. A value of -1 means "don't care".
    bit     pinOn = 0;
    string  pinName = "";
    longint pWait, pLoad, pRen, pWen, pAddr, pStore, pBusy, pOwner, pCnt0, pCnt1;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkPin(input string name, input logic [63:0] act, input longint exp);
        if (exp >= 0) checkVal(name, act, exp[63:0]);
    endtask

    // Single compare process. While reset is high the outputs must show the
    // reset values. Otherwise they must match the model, which then steps to
    // the state after the coming rising edge.
    always @(negedge CLK) begin
        logic [1:0]    ren, wen, eWait;
        logic          r, w, eRen, eWen, eDone;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eStore, eLoad;
        if (RST) begin
            mCur = -1; mPrio = 0; mCnt[0] = 0; mCnt[1] = 0;
            checkVal("rst_memREN",  64'(bus.memREN),  64'd0);
            checkVal("rst_memWEN",  64'(bus.memWEN),  64'd0);
            checkVal("rst_req_wait", 64'(bus.req_wait), 64'd3);
            checkVal("rst_req_load", 64'(bus.req_load), 64'd0);
            checkVal("rst_busy",    64'(bus.busy),    64'd0);
            checkVal("rst_owner",   64'(bus.owner),   64'd0);
            checkVal("rst_txn_cnt", 64'(bus.txn_cnt), 64'd0);
        end else begin
            ren = bus.req_ren;
            wen = bus.req_wen;
            eRen = 0; eWen = 0; eAddr = '0; eStore = '0; eWait = 2'b11; eLoad = '0; eDone = 0;
            r = 0; w = 0;
            if (mCur >= 0) begin
                r      = ren[mCur];
                w      = wen[mCur];
                eWen   = w;
                eRen   = r & ~w;
                eAddr  = bus.req_addr[mCur*AW +: AW];
                eStore = bus.req_store[mCur*DW +: DW];
                eDone  = (r | w) && (bus.ramstate == ACCESS);
                if (eDone) begin
                    eWait = (mCur == 0) ? 2'b10 : 2'b01;
                    eLoad = bus.ramload;
                end
            end
            checkVal("model_memREN",   64'(bus.memREN),   64'(eRen));
            checkVal("model_memWEN",   64'(bus.memWEN),   64'(eWen));
            checkVal("model_memaddr",  64'(bus.memaddr),  64'(eAddr));
            checkVal("model_memstore", 64'(bus.memstore), 64'(eStore));
            checkVal("model_req_wait", 64'(bus.req_wait), 64'(eWait));
            checkVal("model_req_load", 64'(bus.req_load), 64'(eLoad));
            checkVal("model_busy",     64'(bus.busy),     64'(mCur >= 0));
            checkVal("model_owner",    64'(bus.owner),    64'((mCur > 0) ? 1 : 0));
            checkVal("model_cnt0",     64'(bus.txn_cnt[CW-1:0]),    64'(mCnt[0]));
            checkVal("model_cnt1",     64'(bus.txn_cnt[2*CW-1:CW]), 64'(mCnt[1]));

            if (pinOn) begin
                checkPin({pinName, "_wait"},  64'(bus.req_wait), pWait);
                checkPin({pinName, "_load"},  64'(bus.req_load), pLoad);
                checkPin({pinName, "_ren"},   64'(bus.memREN),   pRen);
                checkPin({pinName, "_wen"},   64'(bus.memWEN),   pWen);
                checkPin({pinName, "_addr"},  64'(bus.memaddr),  pAddr);
                checkPin({pinName, "_store"}, 64'(bus.memstore), pStore);
                checkPin({pinName, "_busy"},  64'(bus.busy),     pBusy);
                checkPin({pinName, "_owner"}, 64'(bus.owner),    pOwner);
                checkPin({pinName, "_cnt0"},  64'(bus.txn_cnt[CW-1:0]),    pCnt0);
                checkPin({pinName, "_cnt1"},  64'(bus.txn_cnt[2*CW-1:CW]), pCnt1);
            end

            if (mCur < 0) begin
                if (ren[0] | wen[0] | ren[1] | wen[1]) begin
                    if ((ren[0] | wen[0]) && (ren[1] | wen[1])) mCur = mPrio;
                    else mCur = (ren[1] | wen[1]) ? 1 : 0;
                end
            end else if (!(r | w)) begin
                mCur = -1;
            end else if (eDone) begin
                mCnt[mCur] = (mCnt[mCur] + 1) % (1 << CW);
                mPrio = 1 - mCur;
                mCur = -1;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and clear old pins.
    task automatic applyStimulus(input logic [1:0] ren, input logic [1:0] wen,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                 input logic [1:0] rstate, input logic [DW-1:0] rload);
        @(posedge CLK);
        #1;
        pinOn         = 0;
        bus.req_ren   = ren;
        bus.req_wen   = wen;
        bus.req_addr  = {a1, a0};
        bus.req_store = {s1, s0};
        bus.ramstate  = rstate;
        bus.ramload   = rload;
    endtask

    // Set literal expectations for the cycle just driven.
    task automatic checkOutput(input string name, input longint wt, input longint ld,
                               input longint rn, input longint wn, input longint ad,
                               input longint st, input longint bz, input longint ow,
                               input longint c0, input longint c1);
        pinName = name; pWait = wt; pLoad = ld; pRen = rn; pWen = wn; pAddr = ad;
        pStore = st; pBusy = bz; pOwner = ow; pCnt0 = c0; pCnt1 = c1;
        pinOn = 1;
    endtask

    task automatic resetPulse();
        @(posedge CLK);
        #1;
        pinOn = 0;
        RST = 1'b1;
        bus.req_ren = '0; bus.req_wen = '0; bus.ramstate = FREE;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [1:0]    rq, rr, ww, done;
        logic [AW-1:0] ra [2];
        logic [DW-1:0] rsd [2];
        logic [1:0]    pick, rstate;
        int            own;

        RST = 1'b1;
        bus.req_ren = '0; bus.req_wen = '0; bus.req_addr = '0; bus.req_store = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single read with two BUSY cycles before ACCESS.
        applyStimulus(2'b01, 2'b00, 32'h40, 0, 0, 0, FREE, 0);
        checkOutput("sr_idle", 3, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        applyStimulus(2'b01, 2'b00, 32'h40, 0, 0, 0, RBUSY, 32'h1111);
        checkOutput("sr_busy1", 3, 0, 1, 0, 32'h40, -1, 1, 0, 0, 0);
        applyStimulus(2'b01, 2'b00, 32'h40, 0, 0, 0, RBUSY, 32'h2222);
        checkOutput("sr_busy2", 3, 0, 1, 0, 32'h40, -1, 1, 0, 0, 0);
        applyStimulus(2'b01, 2'b00, 32'h40, 0, 0, 0, ACCESS, 32'hDEADBEEF);
        checkOutput("sr_access", 2, 32'hDEADBEEF, 1, 0, 32'h40, -1, 1, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 32'hDEADBEEF);
        checkOutput("sr_after", 3, 0, 0, 0, 0, -1, 0, 0, 1, 0);

        // Continuous contention: grants alternate 0,1,0,1.
        resetPulse();
        for (int k = 0; k < 4; k++) begin
            own = k % 2;
            applyStimulus(2'b11, 2'b00, 32'h100, 32'h200, 0, 0, FREE, 0);
            checkOutput("ct_idle", 3, 0, 0, 0, 0, -1, 0, 0, -1, -1);
            applyStimulus(2'b11, 2'b00, 32'h100, 32'h200, 0, 0, RBUSY, 0);
            checkOutput("ct_busy", 3, 0, 1, 0, (own == 0) ? 32'h100 : 32'h200, -1, 1, own, -1, -1);
            applyStimulus(2'b11, 2'b00, 32'h100, 32'h200, 0, 0, ACCESS, 32'hA5A5_0000 + k);
            checkOutput("ct_access", (own == 0) ? 2 : 1, 32'hA5A5_0000 + k, 1, 0,
                        (own == 0) ? 32'h100 : 32'h200, -1, 1, own, -1, -1);
        end
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);
        checkOutput("ct_end", 3, 0, 0, 0, 0, 0, 0, 0, 2, 2);

        // Write wins over read on core 1, and the write data path.
        applyStimulus(2'b10, 2'b10, 0, 32'h80, 0, 32'h12345678, FREE, 0);
        checkOutput("wr_idle", 3, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        applyStimulus(2'b10, 2'b10, 0, 32'h80, 0, 32'h12345678, RBUSY, 0);
        checkOutput("wr_busy", 3, 0, 0, 1, 32'h80, 32'h12345678, 1, 1, 2, 2);
        applyStimulus(2'b10, 2'b10, 0, 32'h80, 0, 32'h12345678, ACCESS, 32'h55);
        checkOutput("wr_access", 1, 32'h55, 0, 1, 32'h80, 32'h12345678, 1, 1, 2, 2);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);
        checkOutput("wr_after", 3, 0, 0, 0, 0, 0, 0, 0, 2, 3);

        // ERROR means retry: the grant is held until ACCESS arrives.
        resetPulse();
        applyStimulus(2'b01, 2'b00, 32'h44, 0, 0, 0, FREE, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b01, 2'b00, 32'h44, 0, 0, 0, ERROR, 32'h99);
            checkOutput("er_error", 3, 0, 1, 0, 32'h44, -1, 1, 0, 0, 0);
        end
        applyStimulus(2'b01, 2'b00, 32'h44, 0, 0, 0, ACCESS, 32'h77);
        checkOutput("er_access", 2, 32'h77, 1, 0, 32'h44, -1, 1, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);
        checkOutput("er_after", 3, 0, 0, 0, 0, -1, 0, 0, 1, 0);

        // Abort: core 0 drops its request. Nothing is counted and prio stays 1.
        applyStimulus(2'b01, 2'b00, 32'h48, 0, 0, 0, FREE, 0);
        applyStimulus(2'b01, 2'b00, 32'h48, 0, 0, 0, RBUSY, 0);
        checkOutput("ab_busy", 3, 0, 1, 0, 32'h48, -1, 1, 0, 1, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, RBUSY, 0);
        checkOutput("ab_drop", 3, 0, 0, 0, 0, -1, 1, 0, 1, 0);
        applyStimulus(2'b11, 2'b00, 32'h10, 32'h20, 0, 0, FREE, 0);
        checkOutput("ab_idle", 3, 0, 0, 0, 0, -1, 0, 0, 1, 0);
        applyStimulus(2'b11, 2'b00, 32'h10, 32'h20, 0, 0, RBUSY, 0);
        checkOutput("ab_prio", 3, 0, 1, 0, 32'h20, -1, 1, 1, 1, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);

        // Asynchronous reset while core 1 has a write in flight.
        resetPulse();
        applyStimulus(2'b00, 2'b10, 0, 32'h90, 0, 32'hCAFE, FREE, 0);
        applyStimulus(2'b00, 2'b10, 0, 32'h90, 0, 32'hCAFE, ACCESS, 0);
        applyStimulus(2'b00, 2'b10, 0, 32'h94, 0, 32'hF00D, FREE, 0);
        applyStimulus(2'b00, 2'b10, 0, 32'h94, 0, 32'hF00D, RBUSY, 0);
        checkOutput("ar_inflight", 3, 0, 0, 1, 32'h94, 32'hF00D, 1, 1, 0, 1);
        applyStimulus(2'b00, 2'b10, 0, 32'h94, 0, 32'hF00D, RBUSY, 0);
        #2;
        RST = 1'b1;
        applyStimulus(2'b11, 2'b00, 32'h300, 32'h400, 0, 0, FREE, 0);
        RST = 1'b0;
        checkOutput("ar_idle", 3, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        applyStimulus(2'b11, 2'b00, 32'h300, 32'h400, 0, 0, RBUSY, 0);
        checkOutput("ar_first", 3, 0, 1, 0, 32'h300, -1, 1, 0, 0, 0);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);

        // Counter wrap: sixteen core 0 transactions bring the count back to 0.
        resetPulse();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2'b01, 2'b00, 32'h60, 0, 0, 0, FREE, 0);
            checkOutput("wp_idle", 3, 0, 0, 0, 0, -1, 0, 0, k, 0);
            applyStimulus(2'b01, 2'b00, 32'h60, 0, 0, 0, ACCESS, 32'h600 + k);
            checkOutput("wp_access", 2, 32'h600 + k, 1, 0, 32'h60, -1, 1, 0, k, 0);
        end
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);
        checkOutput("wp_wrapped", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized phase. Requesters hold until served, or occasionally abort.
        rq = '0; rr = '0; ww = '0; done = '0;
        ra[0] = '0; ra[1] = '0; rsd[0] = '0; rsd[1] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rq[i] && !done[i] && $urandom_range(0, 19) != 0) begin
                    rq[i] = 1'b1;
                end else if ($urandom_range(0, 9) < 6) begin
                    pick   = 2'($urandom_range(1, 3));
                    rq[i]  = 1'b1;
                    rr[i]  = pick[0];
                    ww[i]  = pick[1];
                    ra[i]  = $urandom;
                    rsd[i] = $urandom;
                end else begin
                    rq[i] = 1'b0; rr[i] = 1'b0; ww[i] = 1'b0;
                end
            end
            rstate = ($urandom_range(0, 9) < 4) ? ACCESS : 2'($urandom_range(0, 3));
            applyStimulus(rr, ww, ra[0], ra[1], rsd[0], rsd[1], rstate, $urandom);
            #6;
            done = ~bus.req_wait;
        end

        applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, FREE, 0);
        @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter for the single RAM port.
- Sits between the two per-core cache controllers (upstream) and the shared RAM (downstream); its RAM-side outputs are the mem* signals that the system-level testbench mux forwards to RAM.
- Grants one complete RAM transaction at a time, holds it until RAM reports ACCESS, then rotates priority.
- Keeps a per-requester completed-transaction count for debug and verification.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- CW, 16, transaction counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_ren  in  2  read request per requester, index 0 = core 0.
- req_wen  in  2  write request per requester.
- req_addr  in  2*AW  addresses; requester i uses bits [i*AW +: AW].
- req_store  in  2*DW  write data, packed the same way.
- req_wait  out  2  per-requester stall; 0 only in the completion cycle.
- req_load  out  DW  read data, valid for the requester whose req_wait is 0.
- memREN  out  1  RAM read enable.
- memWEN  out  1  RAM write enable.
- memaddr  out  AW  RAM address.
- memstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- owner  out  1  current grant index, valid in BUSY.
- busy  out  1  1 in BUSY state.
- txn_cnt  out  2*CW  completed transactions per requester.

Behaviour:
- Request rule: requester i is active when req_ren[i] | req_wen[i]. A requester holds its request stable until its req_wait is 0.
- States: IDLE, BUSY. Registered owner and priority pointer prio (1 bit; value = the requester favoured on a tie).
- IDLE:
  - No active request: stay in IDLE.
  - Exactly one active request: owner <= that index, go to BUSY.
  - Both active: owner <= prio, go to BUSY.
- BUSY:
  - memREN/memWEN/memaddr/memstore are driven combinationally from the owner's live inputs.
  - If the owner has both req_ren and req_wen high, the write wins: memWEN=1, memREN=0.
  - ramstate==ACCESS (completion cycle):
    - req_wait[owner]=0 and req_load=ramload, both combinational, same cycle.
    - At the clock edge: txn_cnt[owner]++ (wraps modulo 2^CW), prio <= ~owner, go to IDLE.
  - ramstate FREE/BUSY/ERROR: hold the request and stay in BUSY. ERROR is a retry; no error output exists.
  - Owner drops both enables before ACCESS (abort): go to IDLE; prio and txn_cnt unchanged.
- IDLE outputs:
  - memREN=memWEN=0; memaddr=0; memstore=0.
  - Both req_wait=1. Neither requester ever gets req_wait=0 outside its own completion cycle.
- Non-owner outputs: the non-owner's req_wait is always 1.
- Latency:
  - Request seen in cycle n, state IDLE → grant at edge n+1 → RAM enables asserted in cycle n+1.
  - With RAM returning ACCESS immediately, completion is in cycle n+1.
  - Back-to-back: every transaction is followed by at least one IDLE cycle, so a continuous two-requester load alternates grants 0,1,0,1 (with prio=0 after reset).
- req_load: equals ramload whenever any req_wait is 0, otherwise 0.
- busy=1 and owner = registered index in BUSY; busy=0 and owner=0 in IDLE.
- Reset (async, any time, including mid-transaction):
  - State=IDLE, owner=0, prio=0, txn_cnt=0.
  - memREN=memWEN=0, req_wait=2'b11, req_load=0.
  - The in-flight transaction is discarded and not counted.
- Requests arriving during BUSY are not sampled until the return to IDLE. No starvation: the loser of a tie wins the next tie.

Test Plan:
- Single read: RST pulse; core0 ren=1, addr=0x40; RAM returns BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF → memREN=1/memaddr=0x40 from grant cycle; req_wait[0]=0 and req_load=0xDEADBEEF only in ACCESS cycle; txn_cnt[0]=1.
- Simultaneous contention: both cores ren=1 (addr 0x100 / 0x200), RAM ACCESS after 1 cycle, repeated 4 transactions → grant order 0,1,0,1; memaddr 0x100,0x200,0x100,0x200; each txn_cnt=2; req_wait[1] stays 1 throughout core0's grants.
- Write-over-read and data path: core1 ren=wen=1, addr=0x80, store=0x12345678 → memWEN=1, memREN=0, memstore=0x12345678, memaddr=0x80; txn_cnt[1] increments on ACCESS.
- ERROR retry and abort: core0 read, ramstate=ERROR for 3 cycles then ACCESS → stays BUSY with request held, completes once, txn_cnt[0]=1. Separately, core0 drops ren before ACCESS → IDLE next edge, txn_cnt and prio unchanged.
- Async reset mid-transaction: assert RST between clock edges while BUSY with memWEN=1 → memWEN=0, req_wait=2'b11, busy=0, txn_cnt=0 immediately, without waiting for a clock edge; after release, both requesting → core0 granted first.
- Counter wrap (CW=4 build): 16 core0 transactions → txn_cnt[0] returns to 0; txn_cnt[1] unaffected.
